// File: rtl/conv_1d_feeder.sv
// conv_1d_feeder: sends a kernel packet then a signal packet from host-written buffers on a valid/ready stream.
// Define CONV_1D_FEEDER_ZERO_PAD_EN to append K-1 zero beats after the signal packet.
module conv_1d_feeder #(
    parameter int DATA_WIDTH        = 8,
    parameter int MAX_KERNEL_LENGTH = 8,
    parameter int MAX_SIGNAL_LENGTH = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en,
    input  logic                                   wr_sel,
    input  logic [$clog2(MAX_SIGNAL_LENGTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]                  wr_data,
    input  logic [$clog2(MAX_KERNEL_LENGTH):0]     kernel_len,
    input  logic [$clog2(MAX_SIGNAL_LENGTH):0]     signal_len,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   kernel_load,
    output logic [DATA_WIDTH-1:0]                  signal_data,
    output logic                                   signal_vld,
    output logic                                   signal_last,
    input  logic                                   signal_rdy
);
    localparam int KAW = $clog2(MAX_KERNEL_LENGTH);
    localparam int SAW = $clog2(MAX_SIGNAL_LENGTH);
    localparam int CW  = SAW + 1;
    localparam logic [CW-1:0] KMAX = CW'(MAX_KERNEL_LENGTH);
    localparam logic [CW-1:0] SMAX = CW'(MAX_SIGNAL_LENGTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TWO  = CW'(2);
`ifdef CONV_1D_FEEDER_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, KERNEL, GAP, SIGNAL, PAD, DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] kbuf [MAX_KERNEL_LENGTH];
    logic [DATA_WIDTH-1:0] sbuf [MAX_SIGNAL_LENGTH];
    logic [CW-1:0] cnt, cnt_nxt, k_len, s_len, kc, sc, klen_v, slen_v;
    logic [KAW-1:0] kidx;
    logic [SAW-1:0] sidx;
    logic [DATA_WIDTH-1:0] kd, sd, data_nxt;
    logic xfer, wr_ok, k_end, s_end, p_end;
    logic vld_nxt, last_nxt, kload_nxt, busy_nxt, done_nxt;

    assign xfer   = signal_vld & signal_rdy;
    assign wr_ok  = wr_en & (state == IDLE);
    assign kc     = (CW'(kernel_len) > KMAX) ? KMAX : CW'(kernel_len);
    assign sc     = (signal_len > SMAX) ? SMAX : signal_len;
    // lengths are latched on the same edge the first beat is registered, so look through the latch
    assign klen_v = (state == IDLE) ? kc : k_len;
    assign slen_v = (state == IDLE) ? sc : s_len;
    assign k_end  = xfer && cnt == k_len - ONE;
    assign s_end  = xfer && cnt == s_len - ONE;
    assign p_end  = xfer && cnt == k_len - TWO;

    always_ff @(posedge clk) begin
        if (wr_ok && wr_sel) kbuf[wr_addr[KAW-1:0]] <= wr_data;
        if (wr_ok && !wr_sel) sbuf[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            k_len       <= '0;
            s_len       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            kernel_load <= 1'b0;
            signal_data <= '0;
            signal_vld  <= 1'b0;
            signal_last <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            k_len       <= klen_v;
            s_len       <= slen_v;
            busy        <= busy_nxt;
            done        <= done_nxt;
            kernel_load <= kload_nxt;
            signal_data <= data_nxt;
            signal_vld  <= vld_nxt;
            signal_last <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (kc != '0) ? KERNEL : (sc != '0) ? SIGNAL : DONE;
            KERNEL:  if (k_end) state_nxt = (s_len != '0) ? GAP : DONE;
            GAP:     state_nxt = SIGNAL;
            SIGNAL:  if (s_end) state_nxt = (PAD_EN && k_len > ONE) ? PAD : DONE;
            PAD:     if (p_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        cnt_nxt = (state_nxt != state) ? '0 : xfer ? cnt + ONE : cnt;
    end

    // next-output values; a same-cycle host write is forwarded so it wins over the stale buffer word
    always_comb begin
        kidx      = cnt_nxt[KAW-1:0];
        sidx      = cnt_nxt[SAW-1:0];
        kd        = (wr_ok && wr_sel && wr_addr[KAW-1:0] == kidx) ? wr_data : kbuf[kidx];
        sd        = (wr_ok && !wr_sel && wr_addr == sidx) ? wr_data : sbuf[sidx];
        vld_nxt   = state_nxt inside {KERNEL, SIGNAL, PAD};
        kload_nxt = state_nxt == KERNEL;
        busy_nxt  = state_nxt != IDLE;
        done_nxt  = state_nxt == DONE;
        data_nxt  = (state_nxt == KERNEL) ? kd : (state_nxt == SIGNAL) ? sd : '0;
        last_nxt  = (state_nxt == KERNEL) ? (cnt_nxt == klen_v - ONE) :
                    (state_nxt == SIGNAL) ? (cnt_nxt == slen_v - ONE && !(PAD_EN && klen_v > ONE)) :
                    (state_nxt == PAD)    ? (cnt_nxt == klen_v - TWO) : 1'b0;
    end
endmodule

// File: tb/tb_conv_1d_feeder.sv
// tb_conv_1d_feeder: scoreboard bench for conv_1d_feeder; expected beats queued at start, popped on each transfer.
module tb_conv_1d_feeder;
    localparam int MK = 8;
    localparam int MS = 64;

    logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, signal_rdy = 1'b1;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] kernel_len = '0;
    logic [6:0] signal_len = '0;
    logic busy, done, kernel_load, signal_vld, signal_last;
    logic [7:0] signal_data;

    conv_1d_feeder dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .kernel_len(kernel_len), .signal_len(signal_len), .start(start), .busy(busy), .done(done),
        .kernel_load(kernel_load), .signal_data(signal_data), .signal_vld(signal_vld),
        .signal_last(signal_last), .signal_rdy(signal_rdy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0, last_xfer = 0;
    bit stall_mode = 1'b0, gap_pending = 1'b0;
    logic [9:0] sb[$];
    logic [7:0] km [MK];
    logic [7:0] sm [MS];
    logic [3:0] pat = 4'b1001;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0, pk = 1'b0;
    logic [7:0] pd = '0;
    logic [9:0] e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        signal_rdy = stall_mode ? pat[cyc % 4] : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            gap_pending = 1'b0;
        end else begin
            if (gap_pending) begin
                chk("gap_vld", signal_vld, 0);
                chk("gap_kload", kernel_load, 0);
                gap_pending = 1'b0;
            end
            if (pv && !pr) begin
                chk("hold_vld", signal_vld, 1);
                chk("hold_data", signal_data, pd);
                chk("hold_last", signal_last, pl);
                chk("hold_kload", kernel_load, pk);
            end
            if (signal_vld && signal_rdy) begin
                chk("beat_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("beat", {kernel_load, signal_last, signal_data}, e);
                end
                last_xfer = cyc;
                if (kernel_load && signal_last) gap_pending = 1'b1;
            end
            pv = signal_vld; pr = signal_rdy; pd = signal_data; pl = signal_last; pk = kernel_load;
        end
    end

    task automatic wr(input bit sel, input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(a); wr_data = d;
        @(posedge clk) #1;
        wr_en = 1'b0;
        if (sel) km[a % MK] = d; else sm[a] = d;
    endtask

    task automatic push_exp(input int kc, input int sc, input int np, input int scut);
        for (int i = 0; i < kc; i++) sb.push_back({1'b1, i == kc - 1, km[i]});
        for (int i = 0; i < scut; i++) sb.push_back({1'b0, (i == sc - 1) && np == 0, sm[i]});
        if (scut == sc) for (int i = 0; i < np; i++) sb.push_back({1'b0, i == np - 1, 8'h00});
    endtask

    task automatic run(input int kl, input int sl, input bit disturb, input bit wstart);
        int kc, sc, np, nb, t0, n;
        kc = kl > MK ? MK : kl;
        sc = sl > MS ? MS : sl;
        np = 0;
`ifdef CONV_1D_FEEDER_ZERO_PAD_EN
        if (sc > 0 && kc > 1) np = kc - 1;
`endif
        if (wstart) begin
            km[0] = 8'h5a;
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = '0; wr_data = 8'h5a;
        end
        push_exp(kc, sc, np, sc);
        nb = kc + sc + np + ((kc > 0 && sc > 0) ? 1 : 0);
        kernel_len = 4'(kl); signal_len = 7'(sl); start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0; wr_en = 1'b0; t0 = cyc;
        chk("busy_t1", busy, 1);
        chk("vld_t1", signal_vld, nb > 0);
        if (disturb) begin
            @(posedge clk) #1;
            start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'd1; wr_data = 8'hee;
            @(posedge clk) #1;
            start = 1'b0; wr_en = 1'b0;
        end
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk) #1;
            n++;
        end
        chk("done_seen", done, 1);
        chk("sb_empty", sb.size(), 0);
        if (nb > 0) chk("done_lat", cyc - last_xfer, 1);
        if (!stall_mode) chk("pkt_cycles", cyc - t0, nb);
        chk("busy_in_done", busy, 1);
        @(posedge clk) #1;
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        sb.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vld", signal_vld, 0);
        chk("rst_last", signal_last, 0);
        chk("rst_kload", kernel_load, 0);
        chk("rst_data", signal_data, 0);
        rst = 1'b0;
        @(posedge clk) #1;
        for (int i = 0; i < 3; i++) wr(1'b1, i, 8'(i + 1));
        for (int i = 0; i < 4; i++) wr(1'b0, i, 8'(i + 4));
        run(3, 4, 1'b0, 1'b0);
        stall_mode = 1'b1;
        run(3, 4, 1'b0, 1'b0);
        stall_mode = 1'b0;
        run(0, 2, 1'b0, 1'b0);
        run(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < MK; i++) wr(1'b1, i, 8'(8'h10 + i));
        run(15, 4, 1'b1, 1'b0);
        run(8, 4, 1'b0, 1'b1);
        // abort during signal beat 2, then replay from untouched buffers
        push_exp(3, 4, 0, 2);
        kernel_len = 4'd3; signal_len = 7'd4; start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        repeat (6) @(posedge clk) #1;
        chk("rst_mid_beat", {signal_vld, kernel_load, signal_data}, {2'b10, sm[2]});
        rst = 1'b1;
        @(posedge clk) #1;
        chk("rst_mid_vld", signal_vld, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_sb", sb.size(), 0);
        rst = 1'b0;
        sb.delete();
        @(posedge clk) #1;
        run(3, 4, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
